// File: rtl/shader_spi_pkg.sv
// Shared definitions for the shader SPI loader.
//   - spi_state_e     : controller states (IDLE, LOW, HIGH, STALL, HOLD)
//   - CLK_DIV_DEFAULT : default SCLK half-period in clk cycles
//   - div_reload()    : reload value for the 8-bit half-period down-counter
package shader_spi_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_STALL,
        ST_HOLD
    } spi_state_e;

    // The counter runs CLK_DIV-1 down to 0, so the expire strobe lands on
    // the CLK_DIV-th enabled cycle.
    function automatic logic [7:0] div_reload(input int unsigned div);
        return 8'(div - 1);
    endfunction

endpackage

// File: rtl/shader_spi_loader_if.sv
// Host-side byte stream of the shader SPI loader.
//   tx_valid/tx_data/tx_last/tx_ready : byte handshake towards the SPI link
//   rx_valid/rx_data                  : received byte, one-cycle strobe
//   busy/done                         : frame status
// master = host driving bytes, slave = the loader.
interface shader_spi_loader_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;

    modport master (
        output tx_valid, tx_data, tx_last,
        input  tx_ready, rx_valid, rx_data, busy, done
    );

    modport slave (
        input  tx_valid, tx_data, tx_last,
        output tx_ready, rx_valid, rx_data, busy, done
    );
endinterface

// File: rtl/spi_half_period_timer.sv
// 8-bit down-counter pacing the SPI half periods.
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : count while high; reloads while low
//   expire     : one-cycle strobe every CLK_DIV enabled cycles
module spi_half_period_timer
    import shader_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] RELOAD = div_reload(CLK_DIV);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        expire = en && (cnt_q == 8'd0);
        cnt_d  = cnt_q;
        // Holding the counter at RELOAD while disabled means the first
        // enabled cycle always starts a full half period.
        if (!en || expire) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shader_spi_loader.sv
// SPI mode-0 master that streams bytes to a shader chip and returns the
// bytes clocked back on MISO.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   host        : byte stream interface (slave modport)
//   spi_cs      : chip select, active-low
//   spi_sclk    : SPI clock, idle low
//   spi_mosi    : serial data out, MSB first
//   spi_miso    : serial data in, sampled as SCLK rises
module shader_spi_loader
    import shader_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shader_spi_loader_if.slave   host,
    output logic                 spi_cs,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    spi_state_e state_q, state_d;
    logic [6:0] tx_rem_q, tx_rem_d;     // bits still to send after the one on MOSI
    logic       last_q, last_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       done_q, done_d;
    logic       cs_q, cs_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       csw_q, csw_d;           // enforcing minimum CS-high time in IDLE
    logic       tx_ready;
    logic       take;
    logic       timer_en;
    logic       expire;

    assign timer_en = (state_q == ST_LOW) || (state_q == ST_HIGH) ||
                      (state_q == ST_HOLD) || ((state_q == ST_IDLE) && csw_q);

    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (timer_en),
        .expire (expire)
    );

    always_comb begin
        state_d    = state_q;
        tx_rem_d   = tx_rem_q;
        last_d     = last_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        csw_d      = csw_q;
        tx_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_ready = !csw_q;
                if (csw_q && expire) begin
                    csw_d = 1'b0;
                end
            end
            ST_LOW: begin
                if (expire) begin
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], spi_miso};
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (expire) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        mosi_d    = tx_rem_q[6];
                        tx_rem_d  = {tx_rem_q[5:0], 1'b0};
                        state_d   = ST_LOW;
                    end else begin
                        // rx_sh_q already holds bit 0: it was captured on this bit's rising edge.
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_q;
                        if (last_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            // Offer the handshake now so a waiting byte follows with no gap;
                            // otherwise park in STALL (overridden below on a handshake).
                            tx_ready = 1'b1;
                            state_d  = ST_STALL;
                        end
                    end
                end
            end
            ST_STALL: begin
                tx_ready = 1'b1;
            end
            ST_HOLD: begin
                if (expire) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    csw_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Byte acceptance is common to IDLE, HIGH exit and STALL.
        take = host.tx_valid && tx_ready;
        if (take) begin
            tx_rem_d  = host.tx_data[6:0];
            last_d    = host.tx_last;
            bit_cnt_d = 3'd7;
            mosi_d    = host.tx_data[7];
            cs_d      = 1'b0;
            sclk_d    = 1'b0;
            state_d   = ST_LOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_rem_q   <= '0;
            last_q     <= 1'b0;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            csw_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_rem_q   <= tx_rem_d;
            last_q     <= last_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            csw_q      <= csw_d;
        end
    end

    assign spi_cs        = cs_q;
    assign spi_sclk      = sclk_q;
    assign spi_mosi      = mosi_q;
    assign host.tx_ready = tx_ready;
    assign host.rx_valid = rx_valid_q;
    assign host.rx_data  = rx_data_q;
    assign host.done     = done_q;
    assign host.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shader_spi_loader.sv
// Self-checking bench: two loader instances (CLK_DIV=2 and CLK_DIV=1), directed
// and random frames checked against a frame-level model of the SPI link.
module tb_shader_spi_loader;

    localparam int DA = 2;
    localparam int DB = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shader_spi_loader_if ifa ();
    shader_spi_loader_if ifb ();

    logic cs_a, sclk_a, mosi_a, miso_a;
    logic cs_b, sclk_b, mosi_b, miso_b;

    shader_spi_loader #(.CLK_DIV(DA)) dut_a (
        .clk(clk), .rst_n(rst_n), .host(ifa),
        .spi_cs(cs_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
    );
    shader_spi_loader #(.CLK_DIV(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .host(ifb),
        .spi_cs(cs_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
    );

    // Driver state, routed to the selected instance only.
    bit         sel_b = 1'b0;
    bit         loop_mode = 1'b1;
    logic       d_valid = 1'b0;
    logic [7:0] d_data = 8'h00;
    logic       d_last = 1'b0;

    assign ifa.tx_valid = d_valid & ~sel_b;
    assign ifa.tx_data  = d_data;
    assign ifa.tx_last  = d_last;
    assign ifb.tx_valid = d_valid & sel_b;
    assign ifb.tx_data  = d_data;
    assign ifb.tx_last  = d_last;

    logic       m_cs, m_sclk, m_mosi, m_tx_ready, m_rx_valid, m_busy, m_done;
    logic [7:0] m_rx_data;
    assign m_cs       = sel_b ? cs_b : cs_a;
    assign m_sclk     = sel_b ? sclk_b : sclk_a;
    assign m_mosi     = sel_b ? mosi_b : mosi_a;
    assign m_tx_ready = sel_b ? ifb.tx_ready : ifa.tx_ready;
    assign m_rx_valid = sel_b ? ifb.rx_valid : ifa.rx_valid;
    assign m_rx_data  = sel_b ? ifb.rx_data : ifa.rx_data;
    assign m_busy     = sel_b ? ifb.busy : ifa.busy;
    assign m_done     = sel_b ? ifb.done : ifa.done;

    // MISO: loopback of MOSI, or a bit stream indexed by rising SCLK edges seen so far.
    bit   ms [256];
    int   edges;
    logic pat_bit;
    assign pat_bit = ms[edges[7:0]];
    assign miso_a  = loop_mode ? mosi_a : pat_bit;
    assign miso_b  = loop_mode ? mosi_b : pat_bit;

    // Stimulus description.
    int         nf;
    int         nb [4];
    logic [7:0] txb [4][8];
    logic [7:0] mib [4][8];
    int         dly [4][8];

    // Monitor results.
    int         cs_low, rx_cnt, done_cnt, stall_cnt, high_run, min_high;
    bit         seen_fall, prev_cs, prev_sclk;
    logic       mosi_bits [$];
    logic [7:0] rx_bytes [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        if (rst_n) begin
            if (m_sclk && !prev_sclk) begin
                mosi_bits.push_back(m_mosi);
                edges++;
            end
            if (!m_cs) cs_low++;
            if (m_cs) begin
                high_run++;
            end else if (prev_cs) begin
                if (seen_fall && high_run < min_high) min_high = high_run;
                seen_fall = 1'b1;
                high_run  = 0;
            end
            if (m_rx_valid) begin
                rx_bytes.push_back(m_rx_data);
                rx_cnt++;
            end
            if (m_done) done_cnt++;
            if (!m_cs && !m_sclk && m_tx_ready) stall_cnt++;
        end
        prev_sclk = m_sclk;
        prev_cs   = m_cs;
    end

    task automatic clear_mon();
        edges = 0; cs_low = 0; rx_cnt = 0; done_cnt = 0; stall_cnt = 0;
        high_run = 0; min_high = 1000; seen_fall = 1'b0;
        prev_cs = 1'b1; prev_sclk = 1'b0;
        mosi_bits.delete();
        rx_bytes.delete();
    endtask

    task automatic clear_stim();
        nf = 0;
        for (int f = 0; f < 4; f++) begin
            nb[f] = 0;
            for (int k = 0; k < 8; k++) begin
                txb[f][k] = 8'h00; mib[f][k] = 8'h00; dly[f][k] = 0;
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (m_tx_ready) begin
                @(posedge clk);
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check("timeout_ready", 32'd0, 32'd1);
    endtask

    task automatic drive_frames();
        bit ok;
        int cnt;
        @(negedge clk);
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < nb[f]; k++) begin
                if (k > 0 && dly[f][k] > 0) begin
                    cnt = 0;
                    do begin @(negedge clk); cnt++; end while (!m_rx_valid && cnt < 5000);
                    if (!m_rx_valid) begin
                        check("timeout_rx", 32'd0, 32'd1);
                        d_valid = 1'b0;
                        return;
                    end
                    repeat (dly[f][k] - 1) @(negedge clk);
                end
                d_data  = txb[f][k];
                d_last  = (k == nb[f] - 1);
                d_valid = 1'b1;
                wait_ready(ok);
                if (!ok) begin
                    d_valid = 1'b0;
                    return;
                end
                @(negedge clk);
                if ((f == nf - 1 && k == nb[f] - 1) || (k + 1 < nb[f] && dly[f][k + 1] > 0))
                    d_valid = 1'b0;
            end
        end
        d_valid = 1'b0;
        cnt = 0;
        while (m_busy && cnt < 5000) begin @(negedge clk); cnt++; end
        if (m_busy) check("timeout_busy", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // Frame-level model: each byte is 16 half periods, each frame adds one
    // trailing half period, and every stalled cycle simply extends CS low.
    task automatic verify(input string name);
        int d, n, stall, csl;
        logic [7:0] exp_tx [$];
        logic [7:0] exp_rx [$];
        logic [7:0] got;
        d = sel_b ? DB : DA;
        n = 0; stall = 0; csl = 0;
        for (int f = 0; f < nf; f++) begin
            csl += (16 * nb[f] + 1) * d;
            for (int k = 0; k < nb[f]; k++) begin
                exp_tx.push_back(txb[f][k]);
                exp_rx.push_back(loop_mode ? txb[f][k] : mib[f][k]);
                if (k > 0) stall += dly[f][k];
                n++;
            end
        end
        check({name, "_edges"}, edges, 8 * n);
        check({name, "_cs_low"}, cs_low, csl + stall);
        check({name, "_stall"}, stall_cnt, stall);
        check({name, "_rx_cnt"}, rx_cnt, n);
        check({name, "_done"}, done_cnt, nf);
        for (int i = 0; i < n && 8 * i + 7 < mosi_bits.size(); i++) begin
            got = 8'h00;
            for (int b = 0; b < 8; b++) got = {got[6:0], mosi_bits[8 * i + b]};
            check({name, "_mosi_byte"}, got, exp_tx[i]);
        end
        for (int i = 0; i < n && i < rx_bytes.size(); i++)
            check({name, "_rx_byte"}, rx_bytes[i], exp_rx[i]);
        if (nf > 1) check({name, "_cs_high_min_ok"}, (min_high >= d), 32'd1);
        $display("case %s: inst=%0d frames=%0d bytes=%0d edges=%0d cs_low=%0d stall=%0d",
                 name, sel_b, nf, n, edges, cs_low, stall_cnt);
    endtask

    task automatic run_case(input string name, input bit use_b, input bit loop);
        int p;
        sel_b = use_b;
        loop_mode = loop;
        for (int i = 0; i < 256; i++) ms[i] = 1'b0;
        p = 0;
        for (int f = 0; f < nf; f++)
            for (int k = 0; k < nb[f]; k++)
                for (int b = 7; b >= 0; b--) begin
                    ms[p] = mib[f][k][b];
                    p++;
                end
        clear_mon();
        drive_frames();
        verify(name);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cnt;
        clear_mon();
        clear_stim();
        repeat (2) @(negedge clk);
        check("rst_cs_a", cs_a, 1'b1);
        check("rst_sclk_a", sclk_a, 1'b0);
        check("rst_mosi_a", mosi_a, 1'b0);
        check("rst_rx_valid_a", ifa.rx_valid, 1'b0);
        check("rst_done_a", ifa.done, 1'b0);
        check("rst_busy_a", ifa.busy, 1'b0);
        check("rst_rx_data_a", ifa.rx_data, 8'h00);
        check("rst_cs_b", cs_b, 1'b1);
        rst_n = 1'b1;
        #1;
        check("rel_ready_a", ifa.tx_ready, 1'b1);
        check("rel_ready_b", ifb.tx_ready, 1'b1);

        // Single byte 0xA5, loopback, CLK_DIV=2.
        clear_stim(); nf = 1; nb[0] = 1; txb[0][0] = 8'hA5;
        run_case("a5_single", 1'b0, 1'b1);

        // Three-byte burst, CLK_DIV=1, no gaps.
        clear_stim(); nf = 1; nb[0] = 3;
        txb[0][0] = 8'h12; txb[0][1] = 8'h34; txb[0][2] = 8'h56;
        run_case("burst3_div1", 1'b1, 1'b1);

        // Second byte presented 10 cycles late.
        clear_stim(); nf = 1; nb[0] = 2;
        txb[0][0] = 8'h5A; txb[0][1] = 8'hC7; dly[0][1] = 10;
        run_case("stall10", 1'b0, 1'b1);

        // MISO returns 0x3C while sending 0xFF.
        clear_stim(); nf = 1; nb[0] = 1; txb[0][0] = 8'hFF; mib[0][0] = 8'h3C;
        run_case("miso_3c", 1'b0, 1'b0);

        // Back-to-back frames on both instances.
        clear_stim(); nf = 2; nb[0] = 1; nb[1] = 1; txb[0][0] = 8'h01; txb[1][0] = 8'h80;
        run_case("b2b_div2", 1'b0, 1'b1);
        clear_stim(); nf = 2; nb[0] = 2; nb[1] = 1;
        txb[0][0] = 8'hDE; txb[0][1] = 8'hAD; txb[1][0] = 8'hBE;
        run_case("b2b_div1", 1'b1, 1'b1);

        // Random frames.
        for (int t = 0; t < 16; t++) begin
            clear_stim();
            nf = int'($urandom_range(1, 2));
            for (int f = 0; f < nf; f++) begin
                nb[f] = int'($urandom_range(1, 3));
                for (int k = 0; k < nb[f]; k++) begin
                    txb[f][k] = 8'($urandom);
                    mib[f][k] = 8'($urandom);
                    dly[f][k] = (k > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
                end
            end
            run_case("rnd", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of bit 4, then a clean 0x81 frame.
        sel_b = 1'b0; loop_mode = 1'b1;
        clear_mon();
        @(negedge clk);
        d_data = 8'hC3; d_last = 1'b1; d_valid = 1'b1;
        wait_ready(ok);
        @(negedge clk);
        d_valid = 1'b0;
        cnt = 0;
        while (edges < 4 && cnt < 2000) begin @(negedge clk); cnt++; end
        check("midrst_reached_bit4", (edges >= 4), 32'd1);
        check("midrst_sclk_high_before", cs_a == 1'b0 && sclk_a == 1'b1, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_cs", cs_a, 1'b1);
        check("midrst_sclk", sclk_a, 1'b0);
        check("midrst_busy", ifa.busy, 1'b0);
        repeat (3) @(negedge clk);
        check("midrst_no_rx", rx_cnt, 32'd0);
        check("midrst_no_done", done_cnt, 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_rel_ready", ifa.tx_ready, 1'b1);
        clear_stim(); nf = 1; nb[0] = 1; txb[0][0] = 8'h81;
        run_case("after_rst_81", 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
